accum_job_scheduler: RTL and testbench

//   Shares one integrate/count accumulator between two requesters. Each requester submits a job:
//   a mode (integrate = add 2-bit input each cycle, count = add 1 each cycle) and a length in cycles.
//   The block arbitrates round-robin, clears and sequences the accumulator for the job length,

---
 rtl/accum_job_scheduler.sv | 138 +++++++++++++
 tb/tb_accum_job_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_job_scheduler.sv
// accum_job_scheduler
//   Two requesters share one integrate/count accumulator. A job has a mode
//   (integrate = add the requester's 2-bit sample every cycle, count = add 1
//   every cycle) and a length in cycles. Round-robin arbitration picks the
//   owner. The accumulator is cleared at grant and runs for the job length.
//   The result is returned together with a one-cycle done pulse.
//
// Ports
//   clock    rising-edge clock
//   reset    asynchronous, active-low reset
//   req      per-requester job pending (level, held until done)
//   mode     per-requester mode: 0 = integrate, 1 = count
//   len0/1   job length in cycles for requester 0/1
//   din0/1   integrate sample for requester 0/1
//   grant    one-hot owner of the accumulator while a job runs
//   busy     high while a job is running or completing
//   done     one-cycle pulse; result/overflow/done_id are valid
//   done_id  index of the requester whose job finished
//   result   final accumulator value, held until the next job starts
//   overflow carry-out seen during the last job
module accum_job_scheduler #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [1:0]       din0,
  input  logic [1:0]       din1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic             winner;
  logic             ptr;
  logic             mode_l;
  logic             ovf_acc;
  logic [LEN_W-1:0] remaining;
  logic [WIDTH-1:0] acc;

  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic [WIDTH-1:0] inc;
  logic [WIDTH:0]   sum;

  // The pointer only decides the winner when both requesters are asking.
  always_comb begin
    pick     = (req == 2'b11) ? ptr : req[1];
    pick_len = pick ? len1 : len0;
    inc      = mode_l ? WIDTH'(1) : WIDTH'(winner ? din1 : din0);
    sum      = {1'b0, acc} + {1'b0, inc};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // A zero-length job skips RUN entirely and completes straight away.
  always_comb begin
    next_state = state;
    grant      = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    done_id    = winner;
    case (state)
      IDLE: begin
        if (req != 2'b00)
          next_state = (pick_len == '0) ? DONE : RUN;
      end
      RUN: begin
        grant = winner ? 2'b10 : 2'b01;
        busy  = 1'b1;
        if (remaining == LEN_W'(1))
          next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The running carry is kept privately in ovf_acc so that the visible
  // overflow flag only moves at grant (clear) and on the job's final edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      winner    <= 1'b0;
      ptr       <= 1'b0;
      mode_l    <= 1'b0;
      ovf_acc   <= 1'b0;
      remaining <= '0;
      acc       <= '0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            winner    <= pick;
            mode_l    <= mode[pick];
            remaining <= pick_len;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            overflow  <= 1'b0;
            if (pick_len == '0)
              result <= '0;
          end
        end
        RUN: begin
          acc       <= sum[WIDTH-1:0];
          ovf_acc   <= ovf_acc | sum[WIDTH];
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            result   <= sum[WIDTH-1:0];
            overflow <= ovf_acc | sum[WIDTH];
          end
        end
        DONE: ptr <= ~winner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_job_scheduler.sv
// tb_accum_job_scheduler
//   Self-checking bench for accum_job_scheduler. Each job is predicted from
//   the behavioural rules alone: the winner comes from a round-robin pointer
//   variable, and the result is the plain sum of the increments modulo
//   2**WIDTH. Overflow is set when that plain sum reaches 2**WIDTH.
//   The DUT is built with a 4-bit accumulator so that overflow occurs often.
module tb_accum_job_scheduler;

  localparam int WIDTH = 4;
  localparam int LEN_W = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clock;
  logic             reset;
  logic [1:0]       req;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       din0;
  logic [1:0]       din1;
  logic [1:0]       grant;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;
  logic             overflow;

  int error_count = 0;
  int check_count = 0;
  int ptr_model   = 0;
  int last_result = 0;
  int last_ovf    = 0;

  accum_job_scheduler #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .mode    (mode),
    .len0    (len0),
    .len1    (len1),
    .din0    (din0),
    .din1    (din1),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .overflow(overflow)
  );

  // The clock is free-running. Inputs are driven and outputs are sampled on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compares one observed value with its expected value and counts the check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one whole job starting from an IDLE falling edge.
  // din_fix >= 0 forces both samples to that value; otherwise they are random.
  // When hold is set, req stays at its value through the job and is not dropped at done.
  task automatic applyStimulus(input logic [1:0] req_v, input logic [1:0] mode_v,
                               input int l0, input int l1, input int din_fix,
                               input bit hold);
    int w;
    int n;
    int sum;
    logic m;
    req  = req_v;
    mode = mode_v;
    len0 = LEN_W'(l0);
    len1 = LEN_W'(l1);
    din0 = 2'($urandom_range(0, 3));
    din1 = 2'($urandom_range(0, 3));
    w    = (req_v == 2'b11) ? ptr_model : ((req_v == 2'b10) ? 1 : 0);
    n    = w ? l1 : l0;
    m    = mode_v[w];
    sum  = 0;
    @(posedge clock); @(negedge clock);
    for (int k = 0; k < n; k++) begin
      checkOutput("run_grant", grant, (w != 0) ? 2 : 1);
      checkOutput("run_busy", busy, 1);
      checkOutput("run_done", done, 0);
      checkOutput("result_hold", result, last_result);
      if (k == 0) checkOutput("ovf_clear", overflow, 0);
      if (din_fix >= 0) begin
        din0 = 2'(din_fix);
        din1 = 2'(din_fix);
      end else begin
        din0 = 2'($urandom_range(0, 3));
        din1 = 2'($urandom_range(0, 3));
      end
      sum += m ? 1 : (w != 0 ? int'(din1) : int'(din0));
      if (!hold) begin
        req  = 2'($urandom);
        mode = 2'($urandom);
        len0 = LEN_W'($urandom);
        len1 = LEN_W'($urandom);
      end
      @(posedge clock); @(negedge clock);
    end
    last_result = sum % MODV;
    last_ovf    = (sum >= MODV) ? 1 : 0;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_id", done_id, w);
    checkOutput("done_grant", grant, 0);
    checkOutput("done_busy", busy, 1);
    checkOutput("result", result, last_result);
    checkOutput("overflow", overflow, last_ovf);
    ptr_model = 1 - w;
    if (!hold) req = 2'b00;
    @(posedge clock); @(negedge clock);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_grant", grant, 0);
    checkOutput("idle_result", result, last_result);
    checkOutput("idle_ovf", overflow, last_ovf);
  endtask

  // Checks that every output is at its reset value.
  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_grant"}, grant, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_done_id"}, done_id, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    reset = 1'b0;
    req   = 2'b00;
    mode  = 2'b00;
    len0  = '0;
    len1  = '0;
    din0  = 2'b00;
    din1  = 2'b00;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    // Count job on requester 0, then an integrate job on requester 1 with samples of 3.
    applyStimulus(2'b01, 2'b01, 5, 0, -1, 1'b0);
    applyStimulus(2'b10, 2'b00, 0, 4, 3, 1'b0);

    // Integration that wraps the 4-bit accumulator, then a job that must clear overflow.
    applyStimulus(2'b01, 2'b00, 6, 0, 3, 1'b0);
    applyStimulus(2'b01, 2'b01, 1, 0, -1, 1'b0);

    // Zero-length job.
    applyStimulus(2'b01, 2'b01, 0, 0, -1, 1'b0);

    // Reset pulled low in the middle of a long job.
    req  = 2'b01;
    mode = 2'b01;
    len0 = LEN_W'(10);
    @(posedge clock); @(negedge clock);
    repeat (3) @(negedge clock);
    checkOutput("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    req = 2'b00;
    @(negedge clock);
    check_reset_outputs("abort_hold");
    reset       = 1'b1;
    ptr_model   = 0;
    last_result = 0;
    last_ovf    = 0;
    @(negedge clock);
    applyStimulus(2'b10, 2'b11, 0, 3, -1, 1'b0);

    // Reset, then both requesters held high: grants must alternate.
    reset = 1'b0;
    @(negedge clock);
    reset       = 1'b1;
    ptr_model   = 0;
    last_result = 0;
    last_ovf    = 0;
    @(negedge clock);
    for (int j = 0; j < 3; j++)
      applyStimulus(2'b11, 2'b11, 2, 2, -1, 1'b1);
    req = 2'b00;
    @(negedge clock);

    // Random jobs.
    for (int j = 0; j < 40; j++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      applyStimulus(r, 2'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                    -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
